// File: rtl/decr_hold.sv
// Sequential 2-to-4 decoder: accepts a 2-bit code per valid/ready handshake and holds the
// matching one-hot line for HOLD_CYCLES cycles. Define DECR_GAP_EN for a mandatory idle gap.
module decr_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_valid,
  output logic in_ready,
  input  logic A0,
  input  logic A1,
  output logic Y_0,
  output logic Y_1,
  output logic Y_2,
  output logic Y_3,
  output logic busy,
  output logic done
);

`ifdef DECR_GAP_EN
  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`endif

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [1:0]       r_code, w_code_d;
  logic [3:0]       r_y, w_y_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_state == StHold) && (r_cnt == '0);
`ifdef DECR_GAP_EN
  assign in_ready = en && (r_state == StIdle);
`else
  assign in_ready = en && ((r_state == StIdle) || w_last);
`endif
  assign w_accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_code  <= 2'b00;
      r_y     <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_code  <= w_code_d;
      r_y     <= w_y_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_code_d  = r_code;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StHold;
          w_cnt_d   = HoldLoad;
          w_code_d  = {A1, A0};
        end
      end
      StHold: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else if (w_accept) begin
          // Only reachable without the gap: seamless reload with the new code
          w_cnt_d  = HoldLoad;
          w_code_d = {A1, A0};
        end else begin
`ifdef DECR_GAP_EN
          w_state_d = StGap;
`else
          w_state_d = StIdle;
`endif
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Output logic, registered so Y/busy/done come straight from flops
  always_comb begin
    w_y_d    = 4'b0000;
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    if (w_state_d == StHold) begin
      w_y_d    = 4'b0001 << w_code_d;
      w_done_d = (w_cnt_d == '0);
    end
    if (w_state_d != StIdle) begin
      w_busy_d = 1'b1;
    end
  end

  assign Y_0  = r_y[0];
  assign Y_1  = r_y[1];
  assign Y_2  = r_y[2];
  assign Y_3  = r_y[3];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_decr_hold.sv
// Self-checking bench for decr_hold: table-driven sweep with a per-cycle expected-output
// queue, plus sequences for back-to-back, enable, reset and HOLD_CYCLES=1.
module tb_decr_hold;
  localparam int unsigned H = 4;
`ifdef DECR_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en, in_valid, A0, A1;
  logic in_ready, Y_0, Y_1, Y_2, Y_3, busy, done;
  logic en1, v1, a0_1, a1_1;
  logic in_ready1, y1_0, y1_1, y1_2, y1_3, busy1, done1;

  always #5 clk = ~clk;

  decr_hold #(.HOLD_CYCLES(H), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .A0(A0), .A1(A1), .Y_0(Y_0), .Y_1(Y_1), .Y_2(Y_2), .Y_3(Y_3), .busy(busy), .done(done)
  );

  decr_hold #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_valid(v1), .in_ready(in_ready1),
    .A0(a0_1), .A1(a1_1), .Y_0(y1_0), .Y_1(y1_1), .Y_2(y1_2), .Y_3(y1_3), .busy(busy1),
    .done(done1)
  );

  typedef struct {
    logic [3:0] y;
    bit         busy;
    bit         done;
  } exp_t;

  typedef struct {
    bit         en;
    bit         valid;
    logic [1:0] code;
    bit         exp_ready;
    logic [3:0] exp_y;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  exp_t idle_e = '{y: 4'b0000, busy: 1'b0, done: 1'b0};
  int   n_checks = 0;
  int   n_err = 0;
  bit   last_acc;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // One clock of the HOLD_CYCLES=4 instance, checked against the expected-output queue
  task automatic step(input bit e, input bit v, input logic [1:0] c);
    bit exp_rdy;
    en = e; in_valid = v; {A1, A0} = c;
    #1;
    exp_rdy = e && (!cur.busy || (cur.done && !GapEn));
    check("in_ready", {3'b000, in_ready}, {3'b000, exp_rdy});
    last_acc = v && exp_rdy;
    if (last_acc) begin
      for (int k = 0; k < int'(H); k++)
        q.push_back('{y: 4'b0001 << c, busy: 1'b1, done: (k == int'(H) - 1)});
      if (GapEn) q.push_back('{y: 4'b0000, busy: 1'b1, done: 1'b0});
    end
    @(posedge clk); #1;
    cur = (q.size() != 0) ? q.pop_front() : idle_e;
    check("Y", {Y_3, Y_2, Y_1, Y_0}, cur.y);
    check("busy", {3'b000, busy}, {3'b000, cur.busy});
    check("done", {3'b000, done}, {3'b000, cur.done});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && cur.busy; i++) step(1'b1, 1'b0, 2'b00);
    check("drain_idle", {3'b000, busy}, 4'b0000);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{en: 1'b1, valid: 1'b1, code: 2'd0, exp_ready: 1'b1, exp_y: 4'b0001};
    vecs[1] = '{en: 1'b1, valid: 1'b1, code: 2'd1, exp_ready: 1'b1, exp_y: 4'b0010};
    vecs[2] = '{en: 1'b1, valid: 1'b1, code: 2'd2, exp_ready: 1'b1, exp_y: 4'b0100};
    vecs[3] = '{en: 1'b1, valid: 1'b1, code: 2'd3, exp_ready: 1'b1, exp_y: 4'b1000};
    vecs[4] = '{en: 1'b0, valid: 1'b1, code: 2'd2, exp_ready: 1'b0, exp_y: 4'b0000};

    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; A0 = 1'b0; A1 = 1'b0;
    en1 = 1'b0; v1 = 1'b0; a0_1 = 1'b0; a1_1 = 1'b0;
    cur = idle_e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_Y", {Y_3, Y_2, Y_1, Y_0}, 4'b0000);
    check("rst_busy_done", {2'b00, busy, done}, 4'b0000);
    rst_n = 1'b1;

    // Single code 1, then idle
    step(1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'd0);

    // Table sweep: each row applied from IDLE, first held cycle compared to the row
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].valid, vecs[i].code);
      check("tbl_acc", {3'b000, last_acc}, {3'b000, vecs[i].exp_ready});
      check("tbl_Y", {Y_3, Y_2, Y_1, Y_0}, vecs[i].exp_y);
      drain();
    end

    // Back-to-back: code 3 then code 0 with in_valid held
    step(1'b1, 1'b1, 2'd3);
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) step(1'b1, 1'b1, 2'd0);
    check("b2b_acc", {3'b000, last_acc}, 4'b0001);
    check("b2b_Y0", {Y_3, Y_2, Y_1, Y_0}, 4'b0001);
    drain();

    // en low blocks acceptance; en dropped mid-hold lets the hold finish
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2'd1);

    // Reset asserted mid-hold with Y_2 high
    step(1'b1, 1'b1, 2'd2);
    step(1'b1, 1'b0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_Y", {Y_3, Y_2, Y_1, Y_0}, 4'b0000);
    check("mid_rst_busy_done", {2'b00, busy, done}, 4'b0000);
    q.delete();
    cur = idle_e;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 2'd0);

    // HOLD_CYCLES = 1 instance
    en1 = 1'b1; v1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      {a1_1, a0_1} = 2'(c);
      #1;
      check("h1_ready", {3'b000, in_ready1}, 4'b0001);
      @(posedge clk); #1;
      check("h1_Y", {y1_3, y1_2, y1_1, y1_0}, 4'b0001 << c);
      check("h1_done", {2'b00, busy1, done1}, 4'b0011);
      if (GapEn) begin
        check("h1_gap_ready", {3'b000, in_ready1}, 4'b0000);
        @(posedge clk); #1;
        check("h1_gap_Y", {y1_3, y1_2, y1_1, y1_0}, 4'b0000);
        check("h1_gap_busy", {2'b00, busy1, done1}, 4'b0010);
      end
    end
    v1 = 1'b0;
    @(posedge clk); #1;
    check("h1_end_Y", {y1_3, y1_2, y1_1, y1_0}, 4'b0000);
    check("h1_end_done", {3'b000, done1}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
